// File: rtl/bp_btb_pkg.sv
// rtl/bp_btb_pkg.sv - shared types, defaults and helpers for the branch target buffer
package bp_btb_pkg;

  localparam int BP_ADDR_W  = 15;
  localparam int BP_INDEX_W = 6;
  localparam int BP_CNT_W   = 2;

  typedef enum logic {
    BP_INIT = 1'b0,
    BP_RUN  = 1'b1
  } bp_state_e;

  typedef struct packed {
    logic                           valid;
    logic [BP_ADDR_W-BP_INDEX_W-1:0] tag;
    logic [BP_ADDR_W-1:0]           target;
    logic [BP_CNT_W-1:0]            cnt;
  } bp_entry_t;

  // Helpers work on 32-bit containers so any configured width can share them.
  function automatic logic [31:0] sat_inc(input logic [31:0] c, input int w);
    logic [31:0] max;
    max = (32'h1 << w) - 32'h1;
    return (c >= max) ? max : c + 32'h1;
  endfunction

  function automatic logic [31:0] sat_dec(input logic [31:0] c, input int w);
    return (c == 32'h0) ? 32'h0 : c - 32'h1;
  endfunction

  function automatic logic [31:0] idx_of(input logic [31:0] a, input int iw);
    return a & ((32'h1 << iw) - 32'h1);
  endfunction

  function automatic logic [31:0] tag_of(input logic [31:0] a, input int iw);
    return a >> iw;
  endfunction

  function automatic logic [31:0] weak_taken(input int w);
    return 32'h1 << (w - 1);
  endfunction

  localparam logic [BP_CNT_W-1:0] BP_CNT_WEAK = BP_CNT_W'(weak_taken(BP_CNT_W));

endpackage

// File: rtl/bp_sat_counter.sv
// rtl/bp_sat_counter.sv - combinational saturating up/down step of a direction counter
module bp_sat_counter
  import bp_btb_pkg::*;
#(
  parameter int CNT_W = BP_CNT_W
) (
  input  logic [CNT_W-1:0] cnt_i,
  input  logic             up_i,
  output logic [CNT_W-1:0] cnt_o
);

  assign cnt_o = up_i ? CNT_W'(sat_inc(32'(cnt_i), CNT_W))
                      : CNT_W'(sat_dec(32'(cnt_i), CNT_W));

endmodule

// File: rtl/bp_btb.sv
// rtl/bp_btb.sv - direct-mapped tagged branch target buffer with post-reset valid sweep
module bp_btb
  import bp_btb_pkg::*;
#(
  parameter int ADDR_W  = BP_ADDR_W,
  parameter int INDEX_W = BP_INDEX_W,
  parameter int CNT_W   = BP_CNT_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] raddr0,
  output logic [ADDR_W-1:0] rdata0,
  output logic              rhit0,
  output logic              rtaken0,
  output logic              ready,
  input  logic              wen,
  input  logic [ADDR_W-1:0] waddr,
  input  logic              wtaken,
  input  logic [ADDR_W-1:0] wdata
);

  localparam int DEPTH = 2 ** INDEX_W;
  localparam int TAG_W = ADDR_W - INDEX_W;
  localparam logic [CNT_W-1:0] CNT_WEAK = CNT_W'(weak_taken(CNT_W));

  typedef struct packed {
    logic              valid;
    logic [TAG_W-1:0]  tag;
    logic [ADDR_W-1:0] target;
    logic [CNT_W-1:0]  cnt;
  } entry_t;

  bp_state_e          state_q, state_d;
  logic [INDEX_W-1:0] ptr_q, ptr_d;
  entry_t             mem_q [DEPTH];

  logic [INDEX_W-1:0] ridx, widx;
  logic [TAG_W-1:0]   rtag, wtag;
  entry_t             rent, went;
  logic               whit;
  logic [CNT_W-1:0]   cnt_step;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= BP_INIT;
      ptr_q   <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
    end
  end

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    if (state_q == BP_INIT) begin
      ptr_d = ptr_q + INDEX_W'(1);
      if (ptr_q == INDEX_W'(DEPTH - 1)) begin
        state_d = BP_RUN;
      end
    end
  end

  assign ready = (state_q == BP_RUN);

  // Fetch lookup sees pre-edge contents; no bypass from a same-cycle update.
  assign ridx    = INDEX_W'(idx_of(32'(raddr0), INDEX_W));
  assign rtag    = TAG_W'(tag_of(32'(raddr0), INDEX_W));
  assign rent    = mem_q[ridx];
  assign rhit0   = ready & rent.valid & (rent.tag == rtag);
  assign rtaken0 = rhit0 & rent.cnt[CNT_W-1];
  assign rdata0  = rtaken0 ? rent.target : raddr0 + ADDR_W'(1);

  assign widx = INDEX_W'(idx_of(32'(waddr), INDEX_W));
  assign wtag = TAG_W'(tag_of(32'(waddr), INDEX_W));
  assign went = mem_q[widx];
  assign whit = went.valid & (went.tag == wtag);

  bp_sat_counter #(
    .CNT_W(CNT_W)
  ) u_sat_counter (
    .cnt_i(went.cnt),
    .up_i (wtaken),
    .cnt_o(cnt_step)
  );

  // The array carries no reset; only valid is rewritten by the sweep.
  always_ff @(posedge clk) begin
    if (state_q == BP_INIT) begin
      mem_q[ptr_q].valid <= 1'b0;
    end else if (wen) begin
      if (whit) begin
        mem_q[widx].cnt <= cnt_step;
        if (wtaken) begin
          mem_q[widx].target <= wdata;
        end
      end else if (wtaken) begin
        mem_q[widx] <= '{valid: 1'b1, tag: wtag, target: wdata, cnt: CNT_WEAK};
      end
    end
  end

endmodule

// File: tb/tb_bp_btb.sv
// tb/tb_bp_btb.sv - directed scoreboard bench for bp_btb
module tb_bp_btb;

  logic        clk = 1'b0;
  logic        rst;
  logic [14:0] raddr0;
  logic [14:0] rdata0;
  logic        rhit0;
  logic        rtaken0;
  logic        ready;
  logic        wen;
  logic [14:0] waddr;
  logic        wtaken;
  logic [14:0] wdata;

  int n_assert = 0;
  int n_fail   = 0;

  typedef struct {
    string       tag;
    logic        hit;
    logic        taken;
    logic [14:0] data;
  } exp_t;

  exp_t exp_q[$];

  always #5 clk = ~clk;

  bp_btb dut (
    .clk    (clk),
    .rst    (rst),
    .raddr0 (raddr0),
    .rdata0 (rdata0),
    .rhit0  (rhit0),
    .rtaken0(rtaken0),
    .ready  (ready),
    .wen    (wen),
    .waddr  (waddr),
    .wtaken (wtaken),
    .wdata  (wdata)
  );

  task automatic chk_ready(input logic exp, input string tag);
    n_assert++;
    assert (ready === exp)
    else begin
      n_fail++;
      $error("FAIL %s ready obs=%0b exp=%0b", tag, ready, exp);
    end
  endtask

  task automatic push_exp(input logic eh, input logic et, input logic [14:0] ed, input string tag);
    exp_t e;
    e.tag   = tag;
    e.hit   = eh;
    e.taken = et;
    e.data  = ed;
    exp_q.push_back(e);
  endtask

  task automatic check_out();
    exp_t e;
    n_assert++;
    assert (exp_q.size() > 0)
    else begin
      n_fail++;
      $error("FAIL scoreboard_empty obs=%0d exp=>0", exp_q.size());
    end
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      n_assert++;
      assert (rhit0 === e.hit)
      else begin
        n_fail++;
        $error("FAIL %s rhit0 obs=%0b exp=%0b", e.tag, rhit0, e.hit);
      end
      n_assert++;
      assert (rtaken0 === e.taken)
      else begin
        n_fail++;
        $error("FAIL %s rtaken0 obs=%0b exp=%0b", e.tag, rtaken0, e.taken);
      end
      n_assert++;
      assert (rdata0 === e.data)
      else begin
        n_fail++;
        $error("FAIL %s rdata0 obs=%h exp=%h", e.tag, rdata0, e.data);
      end
    end
  endtask

  task automatic look(input logic [14:0] a, input logic eh, input logic et,
                      input logic [14:0] ed, input string tag);
    raddr0 = a;
    push_exp(eh, et, ed, tag);
    #1;
    check_out();
  endtask

  task automatic upd(input logic [14:0] a, input logic t, input logic [14:0] d);
    wen    = 1'b1;
    waddr  = a;
    wtaken = t;
    wdata  = d;
    @(posedge clk);
    #1;
    wen = 1'b0;
  endtask

  initial begin
    rst    = 1'b1;
    raddr0 = '0;
    wen    = 1'b0;
    waddr  = '0;
    wtaken = 1'b0;
    wdata  = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk_ready(1'b0, "reset_state");
    rst = 1'b0;

    // Init sweep: exactly 64 not-ready edges, lookups forced to miss.
    for (int i = 0; i < 64; i++) begin
      chk_ready(1'b0, $sformatf("init_edge%0d", i));
      if (i == 0) look(15'h0010, 1'b0, 1'b0, 15'h0011, "init_lookup");
      @(posedge clk);
      #1;
    end
    chk_ready(1'b1, "init_done");
    look(15'h0010, 1'b0, 1'b0, 15'h0011, "first_miss");

    // Allocate and alias.
    upd(15'h0010, 1'b1, 15'h0200);
    look(15'h0010, 1'b1, 1'b1, 15'h0200, "alloc_hit");
    look(15'h0050, 1'b0, 1'b0, 15'h0051, "alias_miss");

    // Counter walk: 10 -> 01 -> 10 -> 11 -> 11 -> 10.
    upd(15'h0010, 1'b0, 15'h0777);
    look(15'h0010, 1'b1, 1'b0, 15'h0011, "cnt01");
    repeat (3) upd(15'h0010, 1'b1, 15'h0200);
    look(15'h0010, 1'b1, 1'b1, 15'h0200, "cnt11");
    upd(15'h0010, 1'b0, 15'h0777);
    look(15'h0010, 1'b1, 1'b1, 15'h0200, "cnt_sat_hi");

    // Lower saturation: 10 -> 01 -> 00 -> 00, then one taken gives 01.
    repeat (3) upd(15'h0010, 1'b0, 15'h0777);
    look(15'h0010, 1'b1, 1'b0, 15'h0011, "cnt00");
    upd(15'h0010, 1'b1, 15'h0200);
    look(15'h0010, 1'b1, 1'b0, 15'h0011, "cnt_sat_lo");
    upd(15'h0010, 1'b1, 15'h0200);
    look(15'h0010, 1'b1, 1'b1, 15'h0200, "cnt10_again");

    // Miss not-taken leaves the resident entry; miss taken evicts it.
    upd(15'h0050, 1'b0, 15'h0300);
    look(15'h0010, 1'b1, 1'b1, 15'h0200, "nt_miss_keep");
    look(15'h0050, 1'b0, 1'b0, 15'h0051, "nt_miss_noalloc");
    upd(15'h0050, 1'b1, 15'h0300);
    look(15'h0050, 1'b1, 1'b1, 15'h0300, "evict_new");
    look(15'h0010, 1'b0, 1'b0, 15'h0011, "evict_old");

    look(15'h7FFF, 1'b0, 1'b0, 15'h0000, "wrap");

    // Same-cycle read and update of one index.
    raddr0 = 15'h0020;
    wen    = 1'b1;
    waddr  = 15'h0020;
    wtaken = 1'b1;
    wdata  = 15'h0400;
    push_exp(1'b0, 1'b0, 15'h0021, "same_cycle_old");
    #1;
    check_out();
    @(posedge clk);
    #1;
    wen = 1'b0;
    push_exp(1'b1, 1'b1, 15'h0400, "same_cycle_new");
    #1;
    check_out();

    // Reset mid-run, then again at sweep cycle 20.
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk_ready(1'b0, "async_reset");
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    repeat (20) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 64; i++) begin
      chk_ready(1'b0, $sformatf("resweep_edge%0d", i));
      wen    = (i == 30);
      waddr  = 15'h0005;
      wtaken = 1'b1;
      wdata  = 15'h0500;
      @(posedge clk);
      #1;
    end
    wen = 1'b0;
    chk_ready(1'b1, "resweep_done");
    look(15'h0005, 1'b0, 1'b0, 15'h0006, "init_wen_dropped");
    look(15'h0020, 1'b0, 1'b0, 15'h0021, "resweep_cleared");
    look(15'h0050, 1'b0, 1'b0, 15'h0051, "resweep_cleared2");

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/bp_btb.md
Name: bp_btb

Overview:
- Parametrised branch target buffer; successor to the flat next-PC table in the fetch stage.
- Direct-mapped, tagged and valid-qualified, with a saturating direction counter per entry.
- Fetch reads it combinationally every cycle. The writeback/branch-resolve stage updates it synchronously.
- After reset, a sweep FSM clears all entries while the block reports not-ready.

Parameters:
- ADDR_W, 15, word-address width; addresses occupy bits [ADDR_W:1].
- INDEX_W, 6, index bits; DEPTH = 2**INDEX_W entries.
- CNT_W, 2, direction counter width; MSB set means predict taken.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  reset, asynchronous, active-high.
- raddr0  in  ADDR_W  fetch PC, bits [ADDR_W:1].
- rdata0  out  ADDR_W  predicted next PC.
- rhit0  out  1  lookup hit: valid entry and tag match.
- rtaken0  out  1  hit and counter MSB set.
- ready  out  1  init sweep complete.
- wen  in  1  branch resolve/update strobe.
- waddr  in  ADDR_W  PC of the resolved branch.
- wtaken  in  1  resolved direction.
- wdata  in  ADDR_W  resolved target; used only when wtaken=1.

Behaviour:
- Address split:
  - idx = low INDEX_W bits of the word address.
  - tag = upper ADDR_W-INDEX_W bits.
  - Entry = {valid, tag, target[ADDR_W], cnt[CNT_W]}.
- Read path is purely combinational, zero latency:
  - rhit0 = ready & valid[idx] & (tag[idx]==raddr0 tag).
  - rdata0 = rtaken0 ? target[idx] : raddr0+1.
  - raddr0+1 is truncated to ADDR_W, so all-ones wraps to 0.
- Reads see the pre-edge array contents. There is no write-to-read bypass in the update cycle.
- FSM states: INIT, RUN.
  - rst asserted (any state, any cycle): state=INIT, sweep ptr=0, ready=0, asynchronously.
  - INIT: each clk edge writes valid[ptr]=0 and increments ptr. When ptr==DEPTH-1 is written, the next state is RUN.
  - INIT lasts exactly DEPTH cycles after rst deasserts. ready=1 from the first RUN cycle.
  - RUN: terminal until the next rst.
- While not ready:
  - rhit0=0, rtaken0=0, rdata0=raddr0+1.
  - wen is ignored; updates are dropped, not queued.
- Update, RUN only, on clk edge with wen=1:
  - Hit, taken: cnt saturating +1 (stops at all-ones); target=wdata.
  - Hit, not taken: cnt saturating -1 (stops at 0); target unchanged.
  - Miss, taken: allocate/overwrite entry: valid=1, tag=waddr tag, target=wdata, cnt=weakly-taken (MSB=1, rest 0). Any conflicting entry is evicted.
  - Miss, not taken: no change.
- Simultaneous read and update of the same index: the read returns the old entry. The new entry is visible from the next cycle.
- Reset mid-sweep or mid-run restarts the sweep from 0. Array contents are don't-care except valid, which is fully rewritten before ready.
- No reset value is applied to the array itself. Only valid is guaranteed after INIT.

Decomposition:
- Shared package holds:
  - State encoding BP_INIT/BP_RUN.
  - Entry struct/typedef parametrised by ADDR_W/INDEX_W/CNT_W.
  - Helper functions sat_inc, sat_dec, idx_of, tag_of.
  - Weakly-taken constant.
- One natural sub-module: bp_sat_counter, the combinational CNT_W saturating up/down step.
- Array, FSM and lookup stay in bp_btb.

Test Plan (defaults: DEPTH=64):
- Init:
  - Pulse rst, release.
  - Required: ready=0 for exactly 64 edges, then 1.
  - Then raddr0=0x0010 -> rhit0=0, rdata0=0x0011.
- Allocate/alias:
  - In RUN, update waddr=0x0010, wtaken=1, wdata=0x0200.
  - Next cycle raddr0=0x0010 -> rhit0=1, rtaken0=1, rdata0=0x0200.
  - raddr0=0x0050 (same idx, different tag) -> rhit0=0, rdata0=0x0051.
- Counter/saturation on 0x0010:
  - One not-taken update -> cnt=01, rhit0=1, rtaken0=0, rdata0=0x0011.
  - Three taken updates -> cnt=11.
  - One not-taken update -> cnt=10, rdata0=0x0200.
- Miss/eviction:
  - Not-taken update at 0x0050 -> 0x0010 entry unchanged.
  - Taken update at 0x0050, wdata=0x0300 -> 0x0050 hits with rdata0=0x0300; 0x0010 misses with rdata0=0x0011.
- Wrap and same-cycle update:
  - raddr0=0x7FFF on a miss -> rdata0=0x0000.
  - Update 0x0020 taken->0x0400 while reading 0x0020 in the same cycle -> read is the old miss (0x0021); next cycle reads 0x0400.
- Reset mid-sweep:
  - Assert rst at INIT cycle 20 -> ready stays 0 for 64 edges after release.
  - A wen pulse during INIT leaves no entry: a later lookup misses.
